// File: rtl/gold_nic_pkg.sv
// Shared constants for the gold_nic processor/network interface controller:
// register address map, packet field positions and a VC extraction helper.
package gold_nic_pkg;

    localparam int NIC_DATA_W = 64;
    localparam int NIC_ADDR_W = 2;

    // Processor register map
    typedef enum logic [NIC_ADDR_W-1:0] {
        ADDR_ICB = 2'b00,   // input channel buffer data (read clears)
        ADDR_ISR = 2'b01,   // input status: icb_full in bit 0
        ADDR_OCB = 2'b10,   // output channel buffer data (write only)
        ADDR_OSR = 2'b11    // output status: ocb_full in bit 0
    } nic_addr_e;

    // Packet field positions; the NIC passes every field through untouched
    localparam int VC_BIT      = 63;
    localparam int SX_BIT      = 62;
    localparam int SY_BIT      = 61;
    localparam int DX_MSB      = 55;
    localparam int DX_LSB      = 52;
    localparam int DY_MSB      = 51;
    localparam int DY_LSB      = 48;
    localparam int SRC_MSB     = 47;
    localparam int SRC_LSB     = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    // Virtual channel a packet travels on
    function automatic logic pkt_vc(input logic [NIC_DATA_W-1:0] pkt);
        return pkt[VC_BIT];
    endfunction

endpackage

// File: rtl/gold_nic_if.sv
// Bundle of the processor register bus and the router local-port signals.
//
// Handshake rules (both network directions): a packet moves on a rising edge
// exactly when the sender's strobe (net_so / net_si) and the receiver's ready
// (net_ro / net_ri) are both 1 in the cycle before that edge; the sender holds
// its data stable while its strobe waits, and ready never depends on the
// sender's strobe in the same cycle.
interface gold_nic_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
);
    // Processor side
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              nic_en;
    logic              nic_wr_en;
    // Router local input (NIC -> router)
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;
    logic              net_polarity;
    // Router local output (router -> NIC)
    logic              net_si;
    logic              net_ri;
    logic [DATA_W-1:0] net_di;

    // The NIC's view of the bundle
    modport slave (
        input  addr, d_in, nic_en, nic_wr_en, net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

    // The environment's view (processor plus router)
    modport master (
        output addr, d_in, nic_en, nic_wr_en, net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/gold_nic_slot.sv
// One-entry packet buffer: a data register with a full flag. Load captures
// data and sets full; clear only drops the flag, so the data stays readable.
module gold_nic_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         full
);

    // Load wins over clear; callers never raise both because load needs
    // an empty slot and clear needs a full one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/gold_nic.sv
// gold_nic top: processor register decode, polarity-gated injection into the
// router's local input, reception from its local output, and the registered
// processor read port.
module gold_nic
    import gold_nic_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
) (
    input logic       clk,
    input logic       reset,
    gold_nic_if.slave bus
);

    logic [ADDR_W-1:0] sel;
    logic              rd;
    logic              wr;

    logic              ocb_load;
    logic              ocb_full;
    logic [DATA_W-1:0] ocb_q;
    logic              icb_load;
    logic              icb_clr;
    logic              icb_full;
    logic [DATA_W-1:0] icb_q;
    logic              inject;
    logic [DATA_W-1:0] d_out_q;

    assign sel = bus.addr;
    assign rd  = bus.nic_en & ~bus.nic_wr_en;
    assign wr  = bus.nic_en &  bus.nic_wr_en;

    // A packet enters the router only on the VC matching the current polarity.
    // Writes look at the pre-edge full flag, so a drain cycle never accepts one.
    assign inject   = ocb_full & bus.net_ro & (bus.net_polarity == pkt_vc(ocb_q));
    assign ocb_load = wr & (sel == ADDR_OCB) & ~ocb_full;

    // The ICB is only ready while empty, so arrival and read-clear are exclusive.
    assign icb_load = bus.net_si & ~icb_full;
    assign icb_clr  = rd & (sel == ADDR_ICB) & icb_full;

    gold_nic_slot #(.W(DATA_W)) u_ocb (
        .clk   (clk),
        .reset (reset),
        .load  (ocb_load),
        .clr   (inject),
        .d     (bus.d_in),
        .q     (ocb_q),
        .full  (ocb_full)
    );

    gold_nic_slot #(.W(DATA_W)) u_icb (
        .clk   (clk),
        .reset (reset),
        .load  (icb_load),
        .clr   (icb_clr),
        .d     (bus.net_di),
        .q     (icb_q),
        .full  (icb_full)
    );

    // Registered processor read; anything other than a read returns zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out_q <= '0;
        end else if (rd) begin
            case (sel)
                ADDR_ICB: d_out_q <= icb_q;
                ADDR_ISR: d_out_q <= {{(DATA_W-1){1'b0}}, icb_full};
                ADDR_OSR: d_out_q <= {{(DATA_W-1){1'b0}}, ocb_full};
                default:  d_out_q <= '0;
            endcase
        end else begin
            d_out_q <= '0;
        end
    end

    assign bus.d_out  = d_out_q;
    assign bus.net_so = inject;
    assign bus.net_do = ocb_q;
    assign bus.net_ri = ~icb_full;

endmodule

// File: tb/tb_gold_nic.sv
// Self-checking bench for gold_nic. The reference model treats each channel
// buffer as a queue of capacity one and the expected d_out as a lookup on
// the register map; exp_q/got_q form the injection scoreboard.
module tb_gold_nic;
    import gold_nic_pkg::*;

    localparam int W = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gold_nic_if #(.DATA_W(W), .ADDR_W(2)) bus ();

    gold_nic #(.DATA_W(W), .ADDR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- counters ----------------
    int vectors    = 0;
    int miscompares = 0;

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] ocb_m[$];
    logic [W-1:0] icb_m[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] icb_last;
    logic [W-1:0] exp_dout;

    // observations of the last step
    logic         obs_so, pred_so, obs_ri, pred_ri;
    logic [W-1:0] obs_do, pred_do, obs_dout;
    bit           saw_bbbb;

    task automatic model_reset();
        ocb_m.delete();
        icb_m.delete();
        exp_q.delete();
        got_q.delete();
        icb_last = '0;
        exp_dout = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.addr      = 2'b00;
        bus.d_in      = '0;
        bus.nic_en    = 1'b0;
        bus.nic_wr_en = 1'b0;
        bus.net_si    = 1'b0;
        bus.net_di    = '0;
    endtask

    // Called at a falling edge with inputs already set: records pre-edge
    // outputs, advances the model across the rising edge, then samples d_out
    // at the next falling edge.
    task automatic step();
        logic         wr_ok, rd_icb, arrive;
        logic [W-1:0] nd;
        #1;
        pred_do = (ocb_m.size() != 0) ? ocb_m[0] : '0;
        pred_so = (ocb_m.size() != 0) ? (bus.net_ro && (bus.net_polarity == pred_do[63])) : 1'b0;
        pred_ri = (icb_m.size() == 0);
        obs_so  = bus.net_so;
        obs_do  = bus.net_do;
        obs_ri  = bus.net_ri;
        nd = '0;
        if (bus.nic_en && !bus.nic_wr_en) begin
            case (bus.addr)
                ADDR_ICB: nd = (icb_m.size() != 0) ? icb_m[0] : icb_last;
                ADDR_ISR: nd = W'(icb_m.size());
                ADDR_OSR: nd = W'(ocb_m.size());
                default:  nd = '0;
            endcase
        end
        wr_ok  = bus.nic_en && bus.nic_wr_en && (bus.addr == ADDR_OCB) && (ocb_m.size() == 0);
        rd_icb = bus.nic_en && !bus.nic_wr_en && (bus.addr == ADDR_ICB) && (icb_m.size() != 0);
        arrive = bus.net_si && (icb_m.size() == 0);
        if (pred_so) void'(ocb_m.pop_front());
        if (wr_ok) begin
            ocb_m.push_back(bus.d_in);
            exp_q.push_back(bus.d_in);
        end
        if (rd_icb) icb_last = icb_m.pop_front();
        if (arrive) icb_m.push_back(bus.net_di);
        if (obs_so) got_q.push_back(obs_do);
        if (obs_do[31:0] == 32'h0000_BBBB) saw_bbbb = 1'b1;
        exp_dout = nd;
        @(negedge clk);
        obs_dout = bus.d_out;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [W-1:0] d);
        bus.nic_en = 1'b1; bus.nic_wr_en = 1'b1; bus.addr = a; bus.d_in = d;
        step();
        bus.nic_en = 1'b0; bus.nic_wr_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a);
        bus.nic_en = 1'b1; bus.nic_wr_en = 1'b0; bus.addr = a;
        step();
        bus.nic_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        vectors++; if (bus.net_ri !== 1'b1) begin miscompares++; $display("FAIL reset_ri: got %b expected 1", bus.net_ri); end
        vectors++; if (bus.net_so !== 1'b0) begin miscompares++; $display("FAIL reset_so: got %b expected 0", bus.net_so); end
        vectors++; if (bus.d_out !== '0) begin miscompares++; $display("FAIL reset_dout: got %h expected 0", bus.d_out); end
        vectors++; if (bus.net_do !== '0) begin miscompares++; $display("FAIL reset_do: got %h expected 0", bus.net_do); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cpu_read(ADDR_OSR);
        vectors++; if (obs_dout !== '0) begin miscompares++; $display("FAIL reset_osr: got %h expected 0", obs_dout); end
        cpu_read(ADDR_ISR);
        vectors++; if (obs_dout !== '0) begin miscompares++; $display("FAIL reset_isr: got %h expected 0", obs_dout); end
        vectors++; if (obs_ri !== 1'b1 || obs_so !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got ri=%b so=%b expected ri=1 so=0", obs_ri, obs_so); end
    endtask

    task automatic test_inject_vc0();
        int pulses = 0;
        logic [W-1:0] g;
        bus.net_ro = 1'b1; bus.net_polarity = 1'b1;
        cpu_write(ADDR_OCB, 64'h0000_0000_5000_0001);
        for (int i = 0; i < 6; i++) begin
            bus.net_polarity = ~bus.net_polarity;
            step();
            vectors++; if (obs_so !== pred_so) begin miscompares++; $display("FAIL vc0_so[%0d]: got %b expected %b", i, obs_so, pred_so); end
            if (obs_so === 1'b1) begin
                pulses++;
                vectors++; if (bus.net_polarity !== 1'b0 || obs_do !== 64'h0000_0000_5000_0001) begin miscompares++; $display("FAIL vc0_pkt: got pol=%b do=%h expected pol=0 do=0000000050000001", bus.net_polarity, obs_do); end
            end
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL vc0_pulses: got %0d expected 1", pulses); end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL vc0_sb: got %h expected nothing", g); end
            else if (g !== exp_q[0]) begin miscompares++; $display("FAIL vc0_sb: got %h expected %h", g, exp_q[0]); void'(exp_q.pop_front()); end
            else void'(exp_q.pop_front());
        end
        cpu_read(ADDR_OSR);
        vectors++; if (obs_dout !== '0) begin miscompares++; $display("FAIL vc0_osr: got %h expected 0", obs_dout); end
    endtask

    task automatic test_wait_ready();
        int pulses = 0;
        logic [W-1:0] pkt, g;
        pkt = {1'b1, 31'($urandom), $urandom};
        bus.net_ro = 1'b0; bus.net_polarity = 1'b1;
        cpu_write(ADDR_OCB, pkt);
        for (int i = 0; i < 5; i++) begin
            bus.net_polarity = ~bus.net_polarity;
            step();
            vectors++; if (obs_so !== 1'b0) begin miscompares++; $display("FAIL wait_so[%0d]: got %b expected 0", i, obs_so); end
        end
        cpu_read(ADDR_OSR);
        vectors++; if (obs_dout !== 64'd1) begin miscompares++; $display("FAIL wait_osr: got %h expected 1", obs_dout); end
        bus.net_ro = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.net_polarity = ~bus.net_polarity;
            step();
            vectors++; if (obs_so !== pred_so) begin miscompares++; $display("FAIL wait_so_ro[%0d]: got %b expected %b", i, obs_so, pred_so); end
            if (obs_so === 1'b1) begin
                pulses++;
                vectors++; if (bus.net_polarity !== 1'b1) begin miscompares++; $display("FAIL wait_pol: got %b expected 1", bus.net_polarity); end
            end
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL wait_pulses: got %0d expected 1", pulses); end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            vectors++;
            if (g !== pkt) begin miscompares++; $display("FAIL wait_sb: got %h expected %h", g, pkt); end
        end
        exp_q.delete();
    endtask

    task automatic test_overwrite();
        logic [W-1:0] first, g;
        int pulses = 0;
        first = {1'($urandom), 31'($urandom), 16'h1234, 16'($urandom)};
        saw_bbbb = 1'b0;
        bus.net_ro = 1'b0;
        cpu_write(ADDR_OCB, first);
        cpu_write(ADDR_OCB, {first[63], 31'd0, 32'h0000_BBBB});
        cpu_read(ADDR_OSR);
        vectors++; if (obs_dout !== 64'd1) begin miscompares++; $display("FAIL ovw_osr: got %h expected 1", obs_dout); end
        bus.net_ro = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.net_polarity = ~bus.net_polarity;
            step();
            if (obs_so === 1'b1) pulses++;
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL ovw_pulses: got %0d expected 1", pulses); end
        vectors++; if (saw_bbbb) begin miscompares++; $display("FAIL ovw_bbbb: got 0000bbbb on net_do expected never"); end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            vectors++;
            if (g !== first) begin miscompares++; $display("FAIL ovw_sb: got %h expected %h", g, first); end
        end
        vectors++; if (exp_q.size() != 1) begin miscompares++; $display("FAIL ovw_accepts: got %0d expected 1", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_receive();
        logic [W-1:0] p1, p2;
        p1 = {$urandom, 32'h0000_EE00};
        p2 = {$urandom, 32'h0000_DD00};
        bus.net_ro = 1'b0;
        bus.net_si = 1'b1; bus.net_di = p1;
        step();
        vectors++; if (obs_ri !== 1'b1) begin miscompares++; $display("FAIL rx_ri_before: got %b expected 1", obs_ri); end
        bus.net_si = 1'b0;
        cpu_read(ADDR_ISR);
        vectors++; if (obs_ri !== 1'b0) begin miscompares++; $display("FAIL rx_ri_full: got %b expected 0", obs_ri); end
        vectors++; if (obs_dout !== 64'd1) begin miscompares++; $display("FAIL rx_isr_full: got %h expected 1", obs_dout); end
        bus.net_si = 1'b1; bus.net_di = p2;
        step();
        bus.net_si = 1'b0;
        cpu_read(ADDR_ICB);
        vectors++; if (obs_dout !== p1) begin miscompares++; $display("FAIL rx_icb: got %h expected %h", obs_dout, p1); end
        cpu_read(ADDR_ISR);
        vectors++; if (obs_ri !== 1'b1) begin miscompares++; $display("FAIL rx_ri_after: got %b expected 1", obs_ri); end
        vectors++; if (obs_dout !== '0) begin miscompares++; $display("FAIL rx_isr_empty: got %h expected 0", obs_dout); end
        cpu_read(ADDR_ICB);
        vectors++; if (obs_dout !== p1) begin miscompares++; $display("FAIL rx_stale: got %h expected %h", obs_dout, p1); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] g;
        for (int i = 0; i < 10; i++) begin
            bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
            cpu_write(ADDR_OCB, {1'b0, 31'd0, 32'(i + 100)});
        end
        for (int i = 0; i < 2; i++) step();
        vectors++; if (got_q.size() != 5) begin miscompares++; $display("FAIL b2b_count: got %0d expected 5", got_q.size()); end
        for (int i = 0; got_q.size() != 0; i++) begin
            g = got_q.pop_front();
            vectors++; if (g !== {32'd0, 32'(100 + 2 * i)}) begin miscompares++; $display("FAIL b2b_pkt[%0d]: got %h expected %h", i, g, {32'd0, 32'(100 + 2 * i)}); end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [W-1:0] g;
        for (int i = 0; i < 300; i++) begin
            bus.nic_en       = 1'($urandom_range(0, 1));
            bus.nic_wr_en    = 1'($urandom_range(0, 1));
            bus.addr         = 2'($urandom_range(0, 3));
            bus.d_in         = {$urandom, $urandom};
            bus.net_ro       = ($urandom_range(0, 3) != 0);
            bus.net_polarity = 1'($urandom_range(0, 1));
            bus.net_si       = 1'($urandom_range(0, 1));
            bus.net_di       = {$urandom, $urandom};
            step();
            vectors++; if (obs_so !== pred_so) begin miscompares++; $display("FAIL rnd_so[%0d]: got %b expected %b", i, obs_so, pred_so); end
            vectors++; if (obs_ri !== pred_ri) begin miscompares++; $display("FAIL rnd_ri[%0d]: got %b expected %b", i, obs_ri, pred_ri); end
            vectors++; if (obs_dout !== exp_dout) begin miscompares++; $display("FAIL rnd_dout[%0d]: got %h expected %h", i, obs_dout, exp_dout); end
            if (pred_so) begin
                vectors++; if (obs_do !== pred_do) begin miscompares++; $display("FAIL rnd_do[%0d]: got %h expected %h", i, obs_do, pred_do); end
            end
        end
        set_idle();
        bus.net_ro = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.net_polarity = ~bus.net_polarity;
            step();
        end
        while (got_q.size() != 0) begin
            g = got_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL rnd_sb: got %h expected nothing", g); end
            else if (g !== exp_q[0]) begin miscompares++; $display("FAIL rnd_sb: got %h expected %h", g, exp_q[0]); void'(exp_q.pop_front()); end
            else void'(exp_q.pop_front());
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rnd_pending: got %0d left expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.net_ro = 1'b0; bus.net_polarity = 1'b1;
        cpu_write(ADDR_OCB, {1'b1, 31'd0, 32'hCAFE_0001});
        bus.net_ro = 1'b1;
        #1;
        vectors++; if (bus.net_so !== 1'b1) begin miscompares++; $display("FAIL rst_so_pre: got %b expected 1", bus.net_so); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (bus.net_so !== 1'b0) begin miscompares++; $display("FAIL rst_so_drop: got %b expected 0", bus.net_so); end
        vectors++; if (bus.net_do !== '0 || bus.net_ri !== 1'b1) begin miscompares++; $display("FAIL rst_bufs: got do=%h ri=%b expected do=0 ri=1", bus.net_do, bus.net_ri); end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cpu_read(ADDR_OSR);
        vectors++; if (obs_dout !== '0) begin miscompares++; $display("FAIL rst_osr: got %h expected 0", obs_dout); end
        for (int i = 0; i < 4; i++) begin
            bus.net_polarity = ~bus.net_polarity;
            step();
            if (obs_so !== 1'b0) pulses++;
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL rst_no_inject: got %0d pulses expected 0", pulses); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0;
        bus.net_ro = 1'b0;
        bus.net_polarity = 1'b0;
        set_idle();
        model_reset();
        test_reset();
        test_inject_vc0();
        test_wait_ready();
        test_overwrite();
        test_receive();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
